// File: rtl/mmu_pkg.sv
// Shared types for the MMU feeder: element/row types, feeder FSM states
// and the skew-depth rule used by the activation delay line.
package mmu_pkg;

   localparam int DEF_NUM_INP   = 8;
   localparam int DEF_DATA_SIZE = 15;
   localparam int DEF_NUM_CALC  = 4;

   typedef logic [DEF_DATA_SIZE-1:0] elem_t;
   typedef elem_t [DEF_NUM_INP-1:0]  row_t;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_W,
      FEED,
      FLUSH,
      DONE
   } feeder_state_e;

   // lane i of the activation stream is delayed by i shifts
   function automatic int skew_depth(input int i);
      return i;
   endfunction

endpackage

// File: rtl/mmu_skew_line.sv
// Diagonal skew line: lane i is a chain of skew_depth(i) shift registers.
// Ports: clk, rst_n, shift (common advance), din/dout (packed lanes).
module mmu_skew_line
   import mmu_pkg::*;
#(
   parameter int NUM_INP   = DEF_NUM_INP,
   parameter int DATA_SIZE = DEF_DATA_SIZE
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           shift,
   input  logic [NUM_INP*DATA_SIZE-1:0]   din,
   output logic [NUM_INP*DATA_SIZE-1:0]   dout
);

   for (genvar i = 0; i < NUM_INP; i++) begin : g_lane
      localparam int D = skew_depth(i);
      if (D == 0) begin : g_direct
         assign dout[i*DATA_SIZE +: DATA_SIZE] =
            din[i*DATA_SIZE +: DATA_SIZE];
      end else begin : g_pipe
         logic [DATA_SIZE-1:0] pipe [D];
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int s = 0; s < D; s++) pipe[s] <= '0;
            end else if (shift) begin
               pipe[0] <= din[i*DATA_SIZE +: DATA_SIZE];
               for (int s = 1; s < D; s++) pipe[s] <= pipe[s-1];
            end
         end
         assign dout[i*DATA_SIZE +: DATA_SIZE] = pipe[D-1];
      end
   end

endmodule

// File: rtl/mmu_feeder.sv
// Initiator for MMU_gen: loads weight rows, then feeds skewed activations.
// Ports: start, s_valid/s_ready/s_data in; load, mmu_en, mmu_data,
// busy, calc_cnt, done out. All array-side outputs are registered.
module mmu_feeder
   import mmu_pkg::*;
#(
   parameter int NUM_INP   = DEF_NUM_INP,
   parameter int DATA_SIZE = DEF_DATA_SIZE,
   parameter int NUM_CALC  = DEF_NUM_CALC
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               start,
   input  logic                               s_valid,
   output logic                               s_ready,
   input  logic [NUM_INP*DATA_SIZE-1:0]       s_data,
   output logic                               load,
   output logic                               mmu_en,
   output logic [NUM_INP*DATA_SIZE-1:0]       mmu_data,
   output logic                               busy,
   output logic [$clog2(NUM_CALC+1)-1:0]      calc_cnt,
   output logic                               done
);

   localparam int LW = NUM_INP * DATA_SIZE;
   localparam int RW = $clog2(NUM_INP + 1);
   localparam int CW = $clog2(NUM_CALC + 1);

   feeder_state_e state, state_n;
   logic [RW-1:0] row_cnt, row_n;
   logic [CW-1:0] calc_n, calc_inc;
   logic          load_n, en_n, shift, calc_end;
   logic [LW-1:0] data_n, skew_in, skew_out;
   logic          last_row, last_flush;

   mmu_skew_line #(
      .NUM_INP   (NUM_INP),
      .DATA_SIZE (DATA_SIZE)
   ) u_skew (
      .clk   (clk),
      .rst_n (rst_n),
      .shift (shift),
      .din   (skew_in),
      .dout  (skew_out)
   );

   assign last_row   = int'(row_cnt) == NUM_INP - 1;
   assign last_flush = int'(row_cnt) == NUM_INP - 2;
   assign calc_inc   = calc_cnt + CW'(1);
   assign busy       = state != IDLE;
   assign done       = state == DONE;

   always_comb begin
      state_n  = state;
      row_n    = row_cnt;
      calc_n   = calc_cnt;
      load_n   = 1'b0;
      en_n     = 1'b0;
      data_n   = mmu_data;
      shift    = 1'b0;
      skew_in  = '0;
      s_ready  = 1'b0;
      calc_end = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_n = LOAD_W;
               row_n   = '0;
               calc_n  = '0;
            end
         end
         LOAD_W: begin
            s_ready = 1'b1;
            if (s_valid) begin
               load_n = 1'b1;
               en_n   = 1'b1;
               data_n = s_data;
               if (last_row) begin
                  row_n   = '0;
                  state_n = FEED;
               end else begin
                  row_n = row_cnt + RW'(1);
               end
            end
         end
         FEED: begin
            s_ready = 1'b1;
            skew_in = s_data;
            if (s_valid) begin
               shift  = 1'b1;
               en_n   = 1'b1;
               data_n = skew_out;
               if (last_row) begin
                  row_n = '0;
                  // a single lane has nothing left to drain
                  if (NUM_INP == 1) calc_end = 1'b1;
                  else              state_n  = FLUSH;
               end else begin
                  row_n = row_cnt + RW'(1);
               end
            end
         end
         FLUSH: begin
            shift  = 1'b1;
            en_n   = 1'b1;
            data_n = skew_out;
            if (last_flush) calc_end = 1'b1;
            else            row_n    = row_cnt + RW'(1);
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
      if (calc_end) begin
         calc_n  = calc_inc;
         row_n   = '0;
         state_n = (calc_inc == CW'(NUM_CALC)) ? DONE : LOAD_W;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         row_cnt  <= '0;
         calc_cnt <= '0;
         load     <= 1'b0;
         mmu_en   <= 1'b0;
         mmu_data <= '0;
      end else begin
         state    <= state_n;
         row_cnt  <= row_n;
         calc_cnt <= calc_n;
         load     <= load_n;
         mmu_en   <= en_n;
         mmu_data <= data_n;
      end
   end

endmodule

// File: tb/tb_mmu_feeder.sv
// Randomized bench for mmu_feeder against a diagonal-skew reference model.
// Ports: none (top-level testbench).
module tb_mmu_feeder;

   localparam int N  = 4;
   localparam int DS = 15;
   localparam int NC = 3;
   localparam int LW = N * DS;
   localparam int CW = $clog2(NC + 1);

   logic          clk = 1'b0;
   logic          rst_n, start, s_valid, s_ready;
   logic          load, mmu_en, busy, done;
   logic [LW-1:0] s_data, mmu_data;
   logic [CW-1:0] calc_cnt;

   int checks = 0;
   int failures = 0;

   logic [LW:0]   obs[$];
   logic [LW:0]   exp_q[$];
   int            cnt_hist[$];
   int            n_done = 0;
   logic          after_done = 1'b0;
   logic [CW-1:0] cnt_prev = '0;

   always #5 clk = ~clk;

   mmu_feeder #(
      .NUM_INP   (N),
      .DATA_SIZE (DS),
      .NUM_CALC  (NC)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .s_data   (s_data),
      .load     (load),
      .mmu_en   (mmu_en),
      .mmu_data (mmu_data),
      .busy     (busy),
      .calc_cnt (calc_cnt),
      .done     (done)
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (mmu_en) obs.push_back({load, mmu_data});
         if (calc_cnt != cnt_prev && calc_cnt != '0)
            cnt_hist.push_back(int'(calc_cnt));
         cnt_prev = calc_cnt;
         if (after_done) begin
            check("busy_fall", 64'(busy), 64'(0));
            after_done = 1'b0;
         end
         if (done) begin
            n_done++;
            check("done_cnt", 64'(calc_cnt), 64'(NC));
            check("done_en", 64'(mmu_en), 64'(1));
            after_done = 1'b1;
         end
      end
   end

   task automatic send_row(input logic [LW-1:0] row, input int gap);
      int guard = 0;
      if (gap > 0) begin
         s_valid = 1'b0;
         repeat (gap) @(negedge clk);
      end
      s_valid = 1'b1;
      s_data  = row;
      while (!s_ready && guard < 64) begin
         @(negedge clk);
         guard++;
      end
      check("accept_wait", 64'(guard < 64), 64'(1));
      @(negedge clk);
   endtask

   task automatic pulse_start();
      s_valid = 1'b0;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
   endtask

   // mode 0: A[k][j]=16k+j back-to-back; 1: same with a 3-cycle hole
   // before row 2 plus a stray start; 2: random data and gaps
   task automatic run_calc(input int mode);
      logic [LW-1:0] wr[N];
      logic [LW-1:0] ar[N];
      logic [LW:0]   row;
      int            gap;
      for (int k = 0; k < N; k++)
         for (int j = 0; j < N; j++) begin
            wr[k][j*DS +: DS] = DS'($urandom);
            ar[k][j*DS +: DS] = (mode == 2) ? DS'($urandom)
                                            : DS'(16 * k + j);
         end
      for (int k = 0; k < N; k++) exp_q.push_back({1'b1, wr[k]});
      for (int t = 0; t < 2 * N - 1; t++) begin
         row = '0;
         for (int j = 0; j < N; j++)
            if (t - j >= 0 && t - j < N)
               row[j*DS +: DS] = ar[t-j][j*DS +: DS];
         exp_q.push_back(row);
      end
      if (mode == 1) pulse_start();
      for (int k = 0; k < N; k++) begin
         gap = (mode == 2) ? int'($urandom_range(0, 2)) : 0;
         send_row(wr[k], gap);
      end
      for (int k = 0; k < N; k++) begin
         if (mode == 2)                 gap = int'($urandom_range(0, 2));
         else if (mode == 1 && k == 2)  gap = 3;
         else                           gap = 0;
         send_row(ar[k], gap);
      end
   endtask

   task automatic run_batch(input int first);
      int guard = 0;
      obs.delete();
      exp_q.delete();
      cnt_hist.delete();
      n_done = 0;
      pulse_start();
      check("start_busy", 64'(busy), 64'(1));
      check("start_ready", 64'(s_ready), 64'(1));
      for (int c = 0; c < NC; c++) run_calc(first == 0 ? c : 2);
      s_valid = 1'b0;
      while (n_done == 0 && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      repeat (3) @(negedge clk);
      check("done_pulses", 64'(n_done), 64'(1));
      check("out_count", 64'(obs.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         check($sformatf("out_row%0d", i),
               (i < obs.size()) ? 64'(obs[i]) : '1, 64'(exp_q[i]));
      check("cnt_steps", 64'(cnt_hist.size()), 64'(NC));
      for (int i = 0; i < cnt_hist.size() && i < NC; i++)
         check("cnt_step", 64'(cnt_hist[i]), 64'(i + 1));
      check("cnt_hold", 64'(calc_cnt), 64'(NC));
      check("idle_busy", 64'(busy), 64'(0));
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_load"}, 64'(load), 64'(0));
      check({tag, "_en"}, 64'(mmu_en), 64'(0));
      check({tag, "_data"}, 64'(mmu_data), 64'(0));
      check({tag, "_busy"}, 64'(busy), 64'(0));
      check({tag, "_done"}, 64'(done), 64'(0));
      check({tag, "_cnt"}, 64'(calc_cnt), 64'(0));
      check({tag, "_ready"}, 64'(s_ready), 64'(0));
   endtask

   initial begin
      rst_n   = 1'b0;
      start   = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      repeat (2) @(negedge clk);
      check_zero_outputs("rst");
      rst_n = 1'b1;
      @(negedge clk);

      run_batch(0);

      pulse_start();
      for (int k = 0; k < N + 2; k++)
         send_row(LW'({$urandom, $urandom}), 0);
      s_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1 check_zero_outputs("midrst");
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_busy", 64'(busy), 64'(0));

      run_batch(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mmu_feeder.md
Name: mmu_feeder

Overview:
Upstream driver for the MMU_gen systolic array: the initiator side of its load/data interface.
- Accepts matrix rows over a valid/ready stream.
- Drives the weight-load phase: the load strobe plus unskewed weight rows.
- Then feeds activation rows through a per-lane diagonal skew line so lane i reaches the array i cycles after lane 0.
- Counts completed matrix multiplications and flags completion of a batch.

Parameters:
NUM_INP, 8, cell units per MMU row/column; also lane count and row count per matrix.
DATA_SIZE, 15, bit width of one matrix element.
NUM_CALC, 4, matrix multiplications per batch before done.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a batch when idle
s_valid  in  1  input row valid
s_ready  out  1  input row accepted when s_valid & s_ready
s_data  in  NUM_INP*DATA_SIZE  one matrix row; lane i = bits [i*DATA_SIZE +: DATA_SIZE]
load  out  1  weight-load strobe to MMU_gen
mmu_en  out  1  array advance enable; high on every cycle the array must shift
mmu_data  out  NUM_INP*DATA_SIZE  weight row (load=1) or skewed activation lanes (load=0)
busy  out  1  high in any state except IDLE
calc_cnt  out  $clog2(NUM_CALC+1)  completed multiplications in current batch
done  out  1  one-cycle pulse when batch completes

Behaviour:
Reset (async on rst_n low, released synchronously by design):
- State IDLE.
- All outputs 0.
- Skew registers, row counter and calc_cnt cleared.
- Reset mid-operation aborts the batch; there is no partial-state recovery.

State machine (states IDLE, LOAD_W, FEED, FLUSH, DONE):
- IDLE:
  - start -> LOAD_W; row_cnt=0, calc_cnt=0.
  - start while busy is ignored.
- LOAD_W:
  - s_ready=1.
  - Each accepted row is registered: next cycle load=1, mmu_en=1, mmu_data=row unskewed.
  - No accept -> load=0, mmu_en=0.
  - After NUM_INP accepts -> FEED, row_cnt=0.
- FEED:
  - s_ready=1.
  - On accept, lane 0 receives the row element directly; lane i passes through i pipeline registers.
  - The whole skew line shifts only on accept.
  - Next cycle: mmu_en=1, load=0, mmu_data = skew-line outputs.
  - No accept -> skew line holds, mmu_en=0 (array stalls; systolic alignment preserved).
  - After NUM_INP accepts -> FLUSH.
- FLUSH:
  - s_ready=0.
  - Runs exactly NUM_INP-1 cycles, shifting zeros into every lane.
  - mmu_en=1 each following cycle.
  - Then calc_cnt increments.
  - If the new calc_cnt == NUM_CALC -> DONE; else -> LOAD_W, row_cnt=0.
- DONE:
  - done=1 for one cycle, then IDLE.
  - calc_cnt holds its final value until the next start.

Timing and data rules:
- Output latency: 1 cycle from accept to mmu_data/mmu_en/load (all registered).
- Lane j of the k-th activation row (k=0..NUM_INP-1) appears on mmu_data at output enable index k+j.
- Total enabled output cycles per calc = 2*NUM_INP-1 in FEED+FLUSH, plus NUM_INP in LOAD_W.
- Data passes unmodified; no arithmetic on elements.
- Lanes not yet filled output 0.
- s_ready is combinational from state only, never from s_valid.
- s_valid may drop mid-matrix; row counting resumes on the next accept.
- NUM_INP=1: FLUSH lasts 0 cycles and goes directly to the calc_cnt update.

Decomposition:
Shared package mmu_pkg:
- elem_t (logic [DATA_SIZE-1:0]) and row_t (elem_t [NUM_INP-1:0]).
- State enum feeder_state_e.
- Function skew_depth(i) returning i.

One sub-module, mmu_skew_line:
- NUM_INP lanes of shift-enabled delay.
- Lane i is i registers deep.
- Shared enable and async reset.
- Instantiated once in mmu_feeder.

Test Plan:
- Reset mid-FEED (NUM_INP=4), rst_n low one cycle -> all outputs 0 next edge; state IDLE; skew line zero; a new start runs cleanly.
- NUM_INP=4, NUM_CALC=1, start, 4 weight rows W0..W3 back-to-back -> load=1 and mmu_data=W0..W3 on cycles 1..4 after first accept; s_ready stays high.
- Activation rows with A[k][j]=16*k+j back-to-back, NUM_INP=4 -> mmu_en high 7 cycles; lane 2 shows 0,0,2,18,34,50,0; lane 0 shows 0,16,32,48,0,0,0; calc_cnt=1 and done pulse 1 cycle after FLUSH ends.
- Same stimulus with s_valid low for 3 cycles between rows 1 and 2 -> mmu_en low exactly those 3 cycles; skew output sequence identical to the back-to-back case when enabled cycles are compressed.
- NUM_CALC=4, four full calcs -> calc_cnt steps 1,2,3,4; single done; busy falls the cycle after done; start during busy ignored.
